// File: rtl/spi_io_pkg.sv
// rtl/spi_io_pkg.sv - shared defaults and sequencer state encoding for spi_io_master
package spi_io_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_CLK_DIV    = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SHIFT,
    NEXT,
    STOP,
    DONE
  } state_t;

endpackage

// File: rtl/spi_byte_shifter.sv
// rtl/spi_byte_shifter.sv - single-byte SPI mode-0 shift engine with lead-in delay and clock divider
module spi_byte_shifter
  import spi_io_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CLK_DIV    = DEF_CLK_DIV
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  sample_in,
  output logic                  sclk,
  output logic                  mosi,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  lead_done,
  output logic                  done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);

  logic                  running;
  logic                  lead;
  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  tick;
  logic                  rise;
  logic                  fall;

  // One divider serves both the lead-in half period and every sclk half period.
  assign tick      = running && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign lead_done = tick && lead;
  assign rise      = tick && !lead && !sclk;
  assign fall      = tick && !lead && sclk;
  assign done      = fall && (bit_cnt == BIT_W'(DATA_WIDTH));
  assign rx_data   = shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      lead    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
    end else if (load) begin
      running <= 1'b1;
      lead    <= 1'b1;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= load_data;
      sclk    <= 1'b0;
      mosi    <= load_data[DATA_WIDTH-1];
    end else if (running) begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (lead_done) lead <= 1'b0;
      if (rise) begin
        sclk    <= 1'b1;
        shreg   <= {shreg[DATA_WIDTH-2:0], sample_in};
        bit_cnt <= bit_cnt + 1'b1;
      end
      // After the last falling edge mosi keeps the final bit rather than
      // presenting a received bit.
      if (fall) begin
        sclk <= 1'b0;
        if (done) running <= 1'b0;
        else      mosi    <= shreg[DATA_WIDTH-1];
      end
    end
  end

endmodule

// File: rtl/spi_io_master.sv
// rtl/spi_io_master.sv - buffered byte SPI master; SPI_LOOPBACK_EN feeds mosi back into the receiver
module spi_io_master
  import spi_io_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int CLK_DIV    = DEF_CLK_DIV
) (
  input  logic                  sysClk,
  input  logic                  reset,
  input  logic                  send,
  output logic                  io_complete,
  input  logic [ADDR_WIDTH-1:0] tx_addr,
  input  logic [DATA_WIDTH-1:0] tx_byte,
  input  logic                  tx_wr,
  input  logic [ADDR_WIDTH-1:0] rx_addr,
  output logic [DATA_WIDTH-1:0] rx_byte,
  input  logic                  rx_rd,
  output logic                  spiClk,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  cs
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int LEN_W = ADDR_WIDTH + 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DATA_WIDTH-1:0] txbuf [DEPTH];
  logic [DATA_WIDTH-1:0] rxbuf [DEPTH];

  state_t                state;
  state_t                next_state;
  logic [LEN_W-1:0]      length;
  logic [LEN_W-1:0]      wr_len;
  logic [LEN_W-1:0]      index_inc;
  logic [ADDR_WIDTH-1:0] index;
  logic [DIV_W-1:0]      stop_cnt;
  logic                  armed;
  logic                  start_ok;
  logic                  wr_en;
  logic                  load;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  lead_done;
  logic                  shift_done;
  logic                  sample_in;

`ifdef SPI_LOOPBACK_EN
  logic unused_miso;
  assign sample_in   = mosi;
  assign unused_miso = miso;
`else
  assign sample_in = miso;
`endif

  assign wr_en     = !tx_wr && (state == IDLE);
  assign wr_len    = {1'b0, tx_addr} + 1'b1;
  assign index_inc = {1'b0, index} + 1'b1;
  // A write in the same cycle as send defers the start so the new length is used.
  assign start_ok  = !send && armed && tx_wr;

  always_comb begin
    next_state = state;
    load       = 1'b0;
    load_data  = txbuf[index_inc[ADDR_WIDTH-1:0]];
    case (state)
      IDLE: begin
        load_data = txbuf[0];
        if (start_ok) begin
          if (length != '0) begin
            next_state = START;
            load       = 1'b1;
          end else begin
            next_state = DONE;
          end
        end
      end
      START: if (lead_done) next_state = SHIFT;
      SHIFT: if (shift_done) next_state = NEXT;
      NEXT: begin
        if (index_inc < length) begin
          next_state = START;
          load       = 1'b1;
        end else begin
          next_state = STOP;
        end
      end
      STOP: if (stop_cnt == DIV_W'(CLK_DIV - 1)) next_state = DONE;
      DONE: if (send) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge sysClk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cs          <= 1'b1;
      io_complete <= 1'b0;
      length      <= '0;
      index       <= '0;
      stop_cnt    <= '0;
      armed       <= 1'b0;
    end else begin
      state       <= next_state;
      cs          <= (next_state == IDLE) || (next_state == DONE);
      io_complete <= (next_state == DONE);
      stop_cnt    <= (state == STOP) ? stop_cnt + 1'b1 : '0;
      if (state == IDLE && next_state == START) index <= '0;
      else if (state == NEXT && next_state == START) index <= index_inc[ADDR_WIDTH-1:0];
      if (send) armed <= 1'b1;
      else if (state == IDLE && next_state != IDLE) armed <= 1'b0;
      if (next_state == DONE && state != DONE) length <= '0;
      else if (wr_en && wr_len > length) length <= wr_len;
    end
  end

  always_ff @(posedge sysClk) begin
    if (wr_en) txbuf[tx_addr] <= tx_byte;
    if (state == NEXT) rxbuf[index] <= rx_data;
  end

  always_ff @(posedge sysClk or negedge reset) begin
    if (!reset) rx_byte <= '0;
    else if (!rx_rd) rx_byte <= rxbuf[rx_addr];
  end

  spi_byte_shifter #(
    .DATA_WIDTH(DATA_WIDTH),
    .CLK_DIV   (CLK_DIV)
  ) u_shifter (
    .clk      (sysClk),
    .rst_n    (reset),
    .load     (load),
    .load_data(load_data),
    .sample_in(sample_in),
    .sclk     (spiClk),
    .mosi     (mosi),
    .rx_data  (rx_data),
    .lead_done(lead_done),
    .done     (shift_done)
  );

endmodule

// File: tb/tb_spi_io_master.sv
// tb/tb_spi_io_master.sv - directed self-checking bench for spi_io_master with a mode-0 slave model
module tb_spi_io_master;

  logic       sysClk = 1'b0;
  logic       reset  = 1'b1;
  logic       send   = 1'b1;
  logic       io_complete;
  logic [3:0] tx_addr = '0;
  logic [7:0] tx_byte = '0;
  logic       tx_wr   = 1'b1;
  logic [3:0] rx_addr = '0;
  logic [7:0] rx_byte;
  logic       rx_rd   = 1'b1;
  logic       spiClk;
  logic       mosi;
  logic       miso    = 1'b0;
  logic       cs;

  spi_io_master dut (
    .sysClk     (sysClk),
    .reset      (reset),
    .send       (send),
    .io_complete(io_complete),
    .tx_addr    (tx_addr),
    .tx_byte    (tx_byte),
    .tx_wr      (tx_wr),
    .rx_addr    (rx_addr),
    .rx_byte    (rx_byte),
    .rx_rd      (rx_rd),
    .spiClk     (spiClk),
    .mosi       (mosi),
    .miso       (miso),
    .cs         (cs)
  );

  always #5 sysClk = ~sysClk;

  int cyc = 0;
  always @(posedge sysClk) cyc <= cyc + 1;

  // slave model and bus monitor
  logic [7:0] resp [16];
  logic [7:0] cap  [16];
  logic [7:0] sh = '0;
  logic [7:0] rb;
  logic       prev_cs = 1'b1;
  logic       prev_sclk = 1'b0;
  int rises = 0, total_rises = 0, cs_falls = 0, period_err = 0, last_per = 0, last_rise = 0;

  always @(negedge sysClk) begin
    if (prev_cs && !cs) begin
      rises = 0;
      cs_falls = cs_falls + 1;
      rb = resp[0];
      miso = rb[7];
    end
    if (!prev_sclk && spiClk && !cs) begin
      if (rises % 8 != 0) begin
        last_per = cyc - last_rise;
        if (last_per != 4) period_err = period_err + 1;
      end
      last_rise = cyc;
      sh = {sh[6:0], mosi};
      rises = rises + 1;
      total_rises = total_rises + 1;
      if (rises % 8 == 0 && rises <= 128) cap[rises / 8 - 1] = sh;
    end
    if (prev_sclk && !spiClk && !cs && rises < 128) begin
      rb = resp[rises / 8];
      miso = rb[7 - rises % 8];
    end
    prev_cs = cs;
    prev_sclk = spiClk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge sysClk);
    #1;
  endtask

  task automatic write_tx(input logic [3:0] a, input logic [7:0] d);
    tick();
    tx_addr = a;
    tx_byte = d;
    tx_wr = 1'b0;
    tick();
    tx_wr = 1'b1;
  endtask

  task automatic read_rx(input logic [3:0] a, output logic [7:0] d);
    tick();
    rx_addr = a;
    rx_rd = 1'b0;
    tick();
    rx_rd = 1'b1;
    d = rx_byte;
  endtask

  task automatic wait_rises(input string tag, input int n, input logic need_sclk);
    int k = 0;
    while (!(rises >= n && (!need_sclk || spiClk)) && k < 3000) begin
      tick();
      k++;
    end
    check(tag, 32'(k < 3000), 32'(1));
  endtask

  task automatic wait_complete(input string tag);
    int k = 0;
    while (!io_complete && k < 3000) begin
      tick();
      k++;
    end
    check(tag, 32'(io_complete), 32'(1));
  endtask

  task automatic release_send();
    send = 1'b1;
    tick();
    tick();
  endtask

  logic [7:0] d;
  int f0, r0, k;
  logic [7:0] exp_rx [3];

  initial begin
    for (int i = 0; i < 16; i++) begin
      resp[i] = 8'hA5;
      cap[i] = '0;
    end

    // reset values
    #1 reset = 1'b0;
    repeat (3) tick();
    check("rst_cs", 32'(cs), 32'(1));
    check("rst_sclk", 32'(spiClk), 32'(0));
    check("rst_mosi", 32'(mosi), 32'(0));
    check("rst_done", 32'(io_complete), 32'(0));
    check("rst_rx", 32'(rx_byte), 32'(0));
    reset = 1'b1;
    tick();

    // three-byte transfer, slave answers 0xA5; write during SHIFT must be dropped
    write_tx(4'd0, 8'h41);
    write_tx(4'd1, 8'h0F);
    write_tx(4'd2, 8'h00);
    f0 = cs_falls;
    send = 1'b0;
    wait_rises("t2_shift_reached", 2, 1'b0);
    write_tx(4'd0, 8'hFF);
    wait_complete("t2_complete");
    check("t2_mosi0", 32'(cap[0]), 'h41);
    check("t2_mosi1", 32'(cap[1]), 'h0F);
    check("t2_mosi2", 32'(cap[2]), 'h00);
    check("t2_rises", 32'(rises), 24);
    check("t2_cs_once", 32'(cs_falls - f0), 1);
    check("t2_period", 32'(last_per), 4);
    check("t2_period_err", 32'(period_err), 0);
    check("t2_cs_high", 32'(cs), 32'(1));
    repeat (5) tick();
    check("t2_hold", 32'(io_complete), 32'(1));
    send = 1'b1;
    tick();
    check("t2_release", 32'(io_complete), 32'(0));
    check("t2_release_cs", 32'(cs), 32'(1));
    repeat (10) tick();
    check("t2_no_retrigger", 32'(cs_falls - f0), 1);
`ifdef SPI_LOOPBACK_EN
    exp_rx[0] = 8'h41; exp_rx[1] = 8'h0F; exp_rx[2] = 8'h00;
`else
    exp_rx[0] = 8'hA5; exp_rx[1] = 8'hA5; exp_rx[2] = 8'hA5;
`endif
    for (int i = 0; i < 3; i++) begin
      read_rx(4'(i), d);
      check($sformatf("t2_rx%0d", i), 32'(d), 32'(exp_rx[i]));
    end

    // empty send: completes at once, no SPI activity
    f0 = cs_falls;
    r0 = total_rises;
    send = 1'b0;
    k = 0;
    while (!io_complete && k < 20) begin
      tick();
      k++;
    end
    check("t3_fast", 32'(k <= 2), 32'(1));
    check("t3_complete", 32'(io_complete), 32'(1));
    check("t3_no_cs", 32'(cs_falls - f0), 0);
    check("t3_no_sclk", 32'(total_rises - r0), 0);
    check("t3_sclk_low", 32'(spiClk), 32'(0));
    release_send();

    // earlier ignored write must have left 0x41 at index 0
    resp[0] = 8'h3C;
    resp[1] = 8'hC3;
    write_tx(4'd1, 8'h0F);
    send = 1'b0;
    wait_complete("t5_complete");
    check("t5_rises", 32'(rises), 16);
    check("t5_mosi0", 32'(cap[0]), 'h41);
    check("t5_mosi1", 32'(cap[1]), 'h0F);
    release_send();
`ifdef SPI_LOOPBACK_EN
    exp_rx[0] = 8'h41; exp_rx[1] = 8'h0F;
`else
    exp_rx[0] = 8'h3C; exp_rx[1] = 8'hC3;
`endif
    read_rx(4'd0, d);
    check("t5_rx0", 32'(d), 32'(exp_rx[0]));
    read_rx(4'd1, d);
    check("t5_rx1", 32'(d), 32'(exp_rx[1]));

    // reset during byte 2, then a single-byte transfer
    resp[0] = 8'h11;
    resp[1] = 8'h22;
    resp[2] = 8'h33;
    write_tx(4'd0, 8'h96);
    write_tx(4'd1, 8'h3C);
    write_tx(4'd2, 8'hC3);
    send = 1'b0;
    wait_rises("t4_byte2_reached", 10, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("t4_abort_cs", 32'(cs), 32'(1));
    check("t4_abort_sclk", 32'(spiClk), 32'(0));
    check("t4_abort_done", 32'(io_complete), 32'(0));
    check("t4_abort_rx", 32'(rx_byte), 32'(0));
    send = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    resp[0] = 8'h5A;
    write_tx(4'd0, 8'h55);
    f0 = cs_falls;
    send = 1'b0;
    wait_complete("t4_complete");
    check("t4_rises", 32'(rises), 8);
    check("t4_mosi0", 32'(cap[0]), 'h55);
    check("t4_cs_once", 32'(cs_falls - f0), 1);
    release_send();
    read_rx(4'd0, d);
`ifdef SPI_LOOPBACK_EN
    check("t4_rx0", 32'(d), 'h55);
`else
    check("t4_rx0", 32'(d), 'h5A);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
    $fatal(1);
  end

endmodule
